// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port, with burst
// locking, lock timeout and $0 write filtering behind a one-cycle output register.
module regfile_wr_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned LOCK_TIMEOUT = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [5*NUM_REQ-1:0]  req_reg,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rf_regWrite,
    output logic [4:0]            rf_writeReg,
    output logic [31:0]           rf_writeData,
    output logic [1:0]            grant_id,
    output logic                  lock_abort,
    output logic [CNT_W-1:0]      zero_drop_cnt
);
    localparam int unsigned MAX_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned IDLE_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(LOCK_TIMEOUT);

    typedef enum logic {ARB, LOCK} stateT;

    stateT             state, stateNext;
    logic [IDX_W-1:0]  rrPtr, rrPtrNext, owner, ownerNext, gnt, scanIdx;
    logic [IDLE_W-1:0] idleCnt, idleNext;
    logic              abortNext, gntValid;
    logic [MAX_REQ-1:0] validPad, lastPad, readyPad;
    logic [4:0]        regArr  [MAX_REQ];
    logic [31:0]       dataArr [MAX_REQ];

    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    // Unpack requester buses into fixed 4-entry views indexed by grant
    always_comb begin
        validPad = '0;
        lastPad  = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            regArr[i]  = '0;
            dataArr[i] = '0;
        end
        validPad[NUM_REQ-1:0] = req_valid;
        lastPad[NUM_REQ-1:0]  = req_last;
        for (int i = 0; i < NUM_REQ; i++) begin
            regArr[i]  = req_reg[5*i +: 5];
            dataArr[i] = req_data[32*i +: 32];
        end
    end

    // Grant selection and next-state logic
    always_comb begin
        stateNext = state;
        rrPtrNext = rrPtr;
        ownerNext = owner;
        idleNext  = idleCnt;
        abortNext = 1'b0;
        gntValid  = 1'b0;
        gnt       = '0;
        scanIdx   = rrPtr;
        readyPad  = '0;
        if (!rst) begin
            case (state)
                ARB: begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (!gntValid && validPad[scanIdx]) begin
                            gntValid = 1'b1;
                            gnt      = scanIdx;
                        end
                        scanIdx = nextIdx(scanIdx);
                    end
                    if (gntValid) begin
                        if (lastPad[gnt]) begin
                            rrPtrNext = nextIdx(gnt);
                        end else begin
                            stateNext = LOCK;
                            ownerNext = gnt;
                            idleNext  = '0;
                        end
                    end
                end
                LOCK: begin
                    if (validPad[owner]) begin
                        gntValid = 1'b1;
                        gnt      = owner;
                        idleNext = '0;
                        if (lastPad[owner]) begin
                            stateNext = ARB;
                            rrPtrNext = nextIdx(owner);
                        end
                    end else begin
                        idleNext = idleCnt + IDLE_W'(1);
                        if (idleNext == IDLE_MAX) begin
                            stateNext = ARB;
                            rrPtrNext = nextIdx(owner);
                            abortNext = 1'b1;
                            idleNext  = '0;
                        end
                    end
                end
                default: stateNext = ARB;
            endcase
            if (gntValid) readyPad[gnt] = 1'b1;
        end
    end

    assign req_ready = readyPad[NUM_REQ-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB;
            rrPtr   <= '0;
            owner   <= '0;
            idleCnt <= '0;
        end else begin
            state   <= stateNext;
            rrPtr   <= rrPtrNext;
            owner   <= ownerNext;
            idleCnt <= idleNext;
        end
    end

    // Registered write stage; $0 writes are acknowledged but never enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_regWrite   <= 1'b0;
            rf_writeReg   <= '0;
            rf_writeData  <= '0;
            grant_id      <= '0;
            lock_abort    <= 1'b0;
            zero_drop_cnt <= '0;
        end else begin
            rf_regWrite <= gntValid && (regArr[gnt] != 5'd0);
            lock_abort  <= abortNext;
            if (gntValid) begin
                rf_writeReg  <= regArr[gnt];
                rf_writeData <= dataArr[gnt];
                grant_id     <= gnt;
                if (regArr[gnt] == 5'd0 && zero_drop_cnt != '1)
                    zero_drop_cnt <= zero_drop_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed writes push expected rf
// transactions; a monitor pops one per observed handshake and compares.
module tb_regfile_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_last, req_ready;
    logic [9:0]  req_reg;
    logic [63:0] req_data;
    logic        rf_regWrite, lock_abort;
    logic [4:0]  rf_writeReg;
    logic [31:0] rf_writeData;
    logic [1:0]  grant_id;
    logic [7:0]  zero_drop_cnt;

    logic [1:0]  satReady, satGid;
    logic        satWe, satAbort;
    logic [4:0]  satReg;
    logic [31:0] satData;
    logic [1:0]  satCnt;

    typedef struct packed {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
        logic [1:0]  g;
    } expT;

    expT expQ[$];
    int  nCmp = 0;
    int  nBad = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.NUM_REQ(2), .LOCK_TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
        .req_reg(req_reg), .req_data(req_data), .req_ready(req_ready),
        .rf_regWrite(rf_regWrite), .rf_writeReg(rf_writeReg),
        .rf_writeData(rf_writeData), .grant_id(grant_id),
        .lock_abort(lock_abort), .zero_drop_cnt(zero_drop_cnt)
    );

    // Narrow counter instance sharing the same stimulus, for saturation
    regfile_wr_arbiter #(.NUM_REQ(2), .LOCK_TIMEOUT(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
        .req_reg(req_reg), .req_data(req_data), .req_ready(satReady),
        .rf_regWrite(satWe), .rf_writeReg(satReg),
        .rf_writeData(satData), .grant_id(satGid),
        .lock_abort(satAbort), .zero_drop_cnt(satCnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic we, input logic [4:0] r, input logic [31:0] d,
                        input logic [1:0] g);
        expT e;
        e.we = we; e.r = r; e.d = d; e.g = g;
        expQ.push_back(e);
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l,
                         input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1);
        @(posedge clk);
        #2;
        req_valid = v;
        req_last  = l;
        req_reg   = {r1, r0};
        req_data  = {d1, d0};
    endtask

    task automatic setRst(input logic b);
        @(posedge clk);
        #2;
        rst       = b;
        req_valid = '0;
        req_last  = '0;
        req_reg   = '0;
        req_data  = '0;
    endtask

    // Monitor: a handshake seen before an edge must show up on rf_* after it
    initial begin
        expT  e;
        logic hs;
        forever begin
            @(negedge clk);
            hs = |(req_valid & req_ready);
            @(posedge clk);
            #1;
            if (hs) begin
                if (expQ.size() == 0) begin
                    nCmp++;
                    nBad++;
                    $display("FAIL unexpected_write: got reg %0d, expected none", rf_writeReg);
                end else begin
                    e = expQ.pop_front();
                    chk("rf_regWrite", 32'(rf_regWrite), 32'(e.we));
                    chk("rf_writeReg", 32'(rf_writeReg), 32'(e.r));
                    chk("rf_writeData", rf_writeData, e.d);
                    chk("grant_id", 32'(grant_id), 32'(e.g));
                    chk("sat_regWrite", 32'(satWe), 32'(e.we));
                end
            end else begin
                chk("rf_idle_we", 32'(rf_regWrite), 32'd0);
            end
        end
    end

    initial begin
        logic [1:0] g;
        rst = 1'b1; req_valid = 2'b11; req_last = 2'b11; req_reg = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_we", 32'(rf_regWrite), 32'd0);
        chk("reset_reg", 32'(rf_writeReg), 32'd0);
        chk("reset_data", rf_writeData, 32'd0);
        chk("reset_gid", 32'(grant_id), 32'd0);
        chk("reset_abort", 32'(lock_abort), 32'd0);
        chk("reset_cnt", 32'(zero_drop_cnt), 32'd0);
        setRst(1'b0);

        // Single write from req0
        drive(2'b01, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
        push(1'b1, 5'd5, 32'hDEADBEEF, 2'd0);
        #1 chk("t1_ready", 32'(req_ready), 32'h1);
        drive(2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        // Both requesting single writes: pointer is at 1, so 1,0,1,0
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 2'b11, 5'(10 + k), 32'hA000 + 32'(k), 5'(20 + k), 32'hB000 + 32'(k));
            g = (k % 2 == 0) ? 2'd1 : 2'd0;
            if (g == 2'd1) push(1'b1, 5'(20 + k), 32'hB000 + 32'(k), 2'd1);
            else           push(1'b1, 5'(10 + k), 32'hA000 + 32'(k), 2'd0);
            #1 chk("t2_ready", 32'(req_ready), (g == 2'd1) ? 32'h2 : 32'h1);
        end
        drive(2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        // req1 burst of 3 stalls req0, which is granted right after
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, {(k == 2), 1'b1}, 5'd1, 32'h11, 5'(25 + k), 32'hC000 + 32'(k));
            push(1'b1, 5'(25 + k), 32'hC000 + 32'(k), 2'd1);
            #1 chk("t3_stall_ready", 32'(req_ready), 32'h2);
        end
        drive(2'b11, 2'b11, 5'd1, 32'h11, 5'd25, 32'hC003);
        push(1'b1, 5'd1, 32'h11, 2'd0);
        #1 chk("t3_after_ready", 32'(req_ready), 32'h1);
        drive(2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        // req0 opens a burst then goes idle: lock times out after 8 cycles
        drive(2'b01, 2'b00, 5'd2, 32'h2222, 5'd0, 32'd0);
        push(1'b1, 5'd2, 32'h2222, 2'd0);
        #1 chk("t4_open_ready", 32'(req_ready), 32'h1);
        for (int k = 1; k <= 9; k++) begin
            drive(2'b10, 2'b10, 5'd0, 32'd0, 5'd3, 32'h3333);
            if (k == 9) push(1'b1, 5'd3, 32'h3333, 2'd1);
            #1;
            chk("t4_ready", 32'(req_ready), (k == 9) ? 32'h2 : 32'h0);
            chk("t4_abort", 32'(lock_abort), (k == 9) ? 32'h1 : 32'h0);
        end
        drive(2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        #1 chk("t4_abort_end", 32'(lock_abort), 32'd0);

        // Four writes to $0: acknowledged, dropped and counted
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 2'b01, 5'd0, 32'h1234, 5'd0, 32'd0);
            push(1'b0, 5'd0, 32'h1234, 2'd0);
            #1;
            chk("t5_ready", 32'(req_ready), 32'h1);
            chk("t5_cnt", 32'(zero_drop_cnt), 32'(k));
            chk("t5_sat", 32'(satCnt), 32'(k));
        end
        drive(2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        #1;
        chk("t5_cnt_final", 32'(zero_drop_cnt), 32'd4);
        chk("t5_sat_final", 32'(satCnt), 32'd3);

        // Reset while req1 holds a lock and a write sits in the output stage
        drive(2'b01, 2'b01, 5'd4, 32'h4444, 5'd0, 32'd0);
        push(1'b1, 5'd4, 32'h4444, 2'd0);
        drive(2'b10, 2'b00, 5'd0, 32'd0, 5'd9, 32'h9999);
        push(1'b1, 5'd9, 32'h9999, 2'd1);
        #1 chk("t6_burst_ready", 32'(req_ready), 32'h2);
        setRst(1'b1);
        @(posedge clk);
        #2;
        chk("t6_we", 32'(rf_regWrite), 32'd0);
        chk("t6_reg", 32'(rf_writeReg), 32'd0);
        chk("t6_data", rf_writeData, 32'd0);
        chk("t6_gid", 32'(grant_id), 32'd0);
        chk("t6_cnt", 32'(zero_drop_cnt), 32'd0);
        chk("t6_sat", 32'(satCnt), 32'd0);
        setRst(1'b0);
        drive(2'b11, 2'b11, 5'd6, 32'h6666, 5'd7, 32'h7777);
        push(1'b1, 5'd6, 32'h6666, 2'd0);
        #1 chk("t6_first_ready", 32'(req_ready), 32'h1);
        drive(2'b11, 2'b11, 5'd6, 32'h6666, 5'd7, 32'h7777);
        push(1'b1, 5'd7, 32'h7777, 2'd1);
        #1 chk("t6_second_ready", 32'(req_ready), 32'h2);
        drive(2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
